preprocess_ctrl: RTL and testbench
==================================

PREPROCESS_CTRL -- requirements
Module: preprocess_ctrl

Interface
REQ-001 SHALL have parameter MAX_ROW, default 540, meaning the image height in pixels.
REQ-002 SHALL have parameter MAX_COL, default 540, meaning the image width in pixels and the line-buffer length.
REQ-003 SHALL have port clk, input, 1 bit: the clock.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start_i, input, 1 bit: a one-cycle frame start request.
REQ-006 SHALL have port busy_o, output, 1 bit: high while a frame is in progress.
REQ-007 SHALL have port frame_done_o, output, 1 bit: a one-cycle pulse when the frame completes.
REQ-008 SHALL have port mem_rd_o, output, 1 bit: pixel read request.
REQ-009 SHALL have port mem_addr_o, output, 19 bits: pixel address, row*MAX_COL+col.
REQ-010 SHALL have port mem_ready_i, input, 1 bit: memory accepts the request this cycle.
REQ-011 SHALL have port mem_rvalid_i, input, 1 bit: read data valid; data returns in request order.
REQ-012 SHALL have port data_en_o, output, 1 bit: write strobe to the line buffers.
REQ-013 SHALL have port core_run_o, output, 1 bit: window-scan enable to the line buffers and core.
REQ-014 SHALL have port top_sel_o, output, 2 bits: index of the line buffer holding the top window row.
REQ-015 SHALL have port out_row_o, output, 10 bits: index of the output row currently scanned.

Function
REQ-016 SHALL implement the states IDLE, FILL, RUN, LOAD and DONE, encoded in 3 bits.
REQ-017 IDLE SHALL go to FILL on start_i=1; start_i SHALL be ignored in every other state.
REQ-018 FILL SHALL request rows 0..2, i.e. 3*MAX_COL sequential addresses starting at 0.
REQ-019 FILL SHALL go to RUN on the cycle the 3*MAX_COL-th mem_rvalid_i is received.
REQ-020 A request SHALL count as issued when mem_rd_o=1 and mem_ready_i=1; mem_addr_o SHALL then advance by 1 on the next cycle.
REQ-021 mem_rd_o SHALL drop in the cycle after the phase's last request is issued; mem_addr_o SHALL hold while mem_ready_i=0.
REQ-022 Issued and received beats SHALL use separate counters; a phase SHALL end only when the received count reaches its target.
REQ-023 data_en_o SHALL equal mem_rvalid_i in FILL and LOAD, and SHALL be 0 otherwise.
REQ-024 mem_rvalid_i outside FILL and LOAD SHALL be dropped.
REQ-025 RUN SHALL hold core_run_o=1 for exactly MAX_COL-2 consecutive cycles, timed by an internal 10-bit counter.
REQ-026 On the last RUN cycle, if out_row_o==MAX_ROW-3 the block SHALL go to DONE; otherwise it SHALL go to LOAD.
REQ-027 On leaving RUN for LOAD, out_row_o SHALL increment by 1.
REQ-028 On leaving RUN for LOAD, top_sel_o SHALL advance 0->1->2->0.
REQ-029 LOAD SHALL request the next image row, MAX_COL beats; the row index for fetch row r SHALL be r = out_row_o+2.
REQ-030 LOAD SHALL return to RUN on the MAX_COL-th received beat.
REQ-031 DONE SHALL pulse frame_done_o for one cycle and go to IDLE on the next clock.
REQ-032 busy_o SHALL be 1 in FILL, RUN, LOAD and DONE, and 0 in IDLE.
REQ-033 core_run_o SHALL be 1 only in RUN.
REQ-034 core_run_o and data_en_o SHALL never both be 1 in the same cycle.
REQ-035 mem_addr_o SHALL never exceed MAX_ROW*MAX_COL-1.
REQ-036 Counters SHALL wrap only through explicit compares, never by overflow.
REQ-037 All outputs SHALL be registered, except data_en_o, which is combinational from mem_rvalid_i and state.

Reset
REQ-038 While rst_n=0 at a clock edge, the state SHALL become IDLE.
REQ-039 Reset SHALL clear all counters, mem_addr_o, out_row_o and top_sel_o to 0.
REQ-040 Reset SHALL drive mem_rd_o, core_run_o, busy_o and frame_done_o to 0.
REQ-041 Reset asserted mid-frame SHALL abort immediately with no frame_done_o pulse.
REQ-042 After a mid-frame reset, in-flight mem_rvalid_i SHALL be ignored.
REQ-043 The first start_i after reset SHALL begin a full fresh frame from address 0.

Verification (MAX_ROW=5, MAX_COL=6)
REQ-044 Bench SHALL cover a full frame with mem_ready_i=1 and one-cycle rvalid latency: FILL issues addresses 0..17, then RUN for 4 cycles, LOAD addresses 18..23, RUN, LOAD 24..29, RUN, frame_done_o pulse; exactly 3 RUN windows (12 core_run_o cycles) occur, with out_row_o 0,1,2 and top_sel_o 0,1,2.
REQ-045 Bench SHALL cover backpressure, mem_ready_i toggling 1,0,0,1...: mem_addr_o is held during stalls, each address is issued exactly once, and the address sequence and totals are unchanged.
REQ-046 Bench SHALL cover start_i pulsed during RUN: no effect on the state, addresses or frame_done_o count, which stays 1.
REQ-047 Bench SHALL cover rst_n=0 during the second LOAD: next cycle all outputs are 0 and the state is IDLE; a new start_i restarts at mem_addr_o=0 with top_sel_o=0.
REQ-048 Bench SHALL cover back-to-back frames, start_i on the cycle after frame_done_o: the second frame is identical to the first and busy_o drops for exactly 1 cycle.

Source files
------------

// File: rtl/preprocess_ctrl.sv
// Frame preprocess controller: fills three line buffers, then alternates
// window scans (RUN) with single-row refills (LOAD) until the frame is done.
module preprocess_ctrl #(
    parameter int MAX_ROW = 540,
    parameter int MAX_COL = 540
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        mem_rd_o,
    output logic [18:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic        mem_rvalid_i,
    output logic        data_en_o,
    output logic        core_run_o,
    output logic [1:0]  top_sel_o,
    output logic [9:0]  out_row_o
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] FILL = 3'd1;
    localparam logic [2:0] RUN  = 3'd2;
    localparam logic [2:0] LOAD = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam int CW = $clog2(3 * MAX_COL + 1);
    localparam logic [CW-1:0] FILL_LAST = CW'(3 * MAX_COL - 1);
    localparam logic [CW-1:0] LOAD_LAST = CW'(MAX_COL - 1);
    localparam logic [9:0]    RUN_LAST  = 10'(MAX_COL - 3);
    localparam logic [9:0]    ROW_LAST  = 10'(MAX_ROW - 3);
    localparam logic [18:0]   ADDR_LAST = 19'(MAX_ROW * MAX_COL - 1);

    logic [2:0]    state;
    logic [CW-1:0] iss_cnt;
    logic [CW-1:0] rcv_cnt;
    logic [CW-1:0] beat_last;
    logic [9:0]    run_cnt;
    logic [18:0]   next_row_base;
    logic          issue;

    assign issue     = mem_rd_o & mem_ready_i;
    assign data_en_o = mem_rvalid_i & ((state == FILL) | (state == LOAD));

    always_comb begin
        beat_last = (state == FILL) ? FILL_LAST : LOAD_LAST;
    end

    // Next fetch row is out_row+2 after the increment, i.e. current out_row+3.
    always_comb begin
        next_row_base = ({9'd0, out_row_o} + 19'd3) * 19'(MAX_COL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            mem_rd_o     <= 1'b0;
            mem_addr_o   <= '0;
            core_run_o   <= 1'b0;
            top_sel_o    <= '0;
            out_row_o    <= '0;
            iss_cnt      <= '0;
            rcv_cnt      <= '0;
            run_cnt      <= '0;
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= FILL;
                        busy_o     <= 1'b1;
                        mem_rd_o   <= 1'b1;
                        mem_addr_o <= '0;
                        out_row_o  <= '0;
                        top_sel_o  <= '0;
                        iss_cnt    <= '0;
                        rcv_cnt    <= '0;
                        run_cnt    <= '0;
                    end
                end
                FILL, LOAD: begin
                    if (issue) begin
                        iss_cnt <= iss_cnt + 1'b1;
                        if (iss_cnt == beat_last) begin
                            mem_rd_o <= 1'b0;
                        end
                        // The final pixel of the frame leaves the address parked in range.
                        if (mem_addr_o != ADDR_LAST) begin
                            mem_addr_o <= mem_addr_o + 19'd1;
                        end
                    end
                    if (mem_rvalid_i) begin
                        if (rcv_cnt == beat_last) begin
                            state      <= RUN;
                            core_run_o <= 1'b1;
                            run_cnt    <= '0;
                            rcv_cnt    <= '0;
                            iss_cnt    <= '0;
                        end else begin
                            rcv_cnt <= rcv_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    run_cnt <= run_cnt + 10'd1;
                    if (run_cnt == RUN_LAST) begin
                        core_run_o <= 1'b0;
                        run_cnt    <= '0;
                        if (out_row_o == ROW_LAST) begin
                            state        <= DONE;
                            frame_done_o <= 1'b1;
                        end else begin
                            state      <= LOAD;
                            mem_rd_o   <= 1'b1;
                            mem_addr_o <= next_row_base;
                            out_row_o  <= out_row_o + 10'd1;
                            top_sel_o  <= (top_sel_o == 2'd2) ? 2'd0 : top_sel_o + 2'd1;
                            iss_cnt    <= '0;
                            rcv_cnt    <= '0;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy_o     <= 1'b0;
                    mem_rd_o   <= 1'b0;
                    core_run_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_preprocess_ctrl.sv
// Scoreboard bench for preprocess_ctrl: the driver queues each frame's expected
// address stream and scan windows; a negedge monitor plays memory and checks.
module tb_preprocess_ctrl;

    localparam int MAX_ROW = 5;
    localparam int MAX_COL = 6;
    localparam int NPIX    = MAX_ROW * MAX_COL;
    localparam int NWIN    = MAX_ROW - 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        mem_ready_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic        busy_o, frame_done_o, mem_rd_o, data_en_o, core_run_o;
    logic [18:0] mem_addr_o;
    logic [1:0]  top_sel_o;
    logic [9:0]  out_row_o;

    always #5 clk = ~clk;

    preprocess_ctrl #(.MAX_ROW(MAX_ROW), .MAX_COL(MAX_COL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .mem_rd_o     (mem_rd_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rvalid_i (mem_rvalid_i),
        .data_en_o    (data_en_o),
        .core_run_o   (core_run_o),
        .top_sel_o    (top_sel_o),
        .out_row_o    (out_row_o)
    );

    int checks = 0;
    int errors = 0;
    int exp_addr[$];
    int exp_row[$];
    int exp_top[$];
    int exp_done = 0;
    int mode = 0;      // 0: always ready, 1: ready 1,0,0 pattern, 2: random ready and latency
    int ph = 0;
    int inflight = 0;
    int rcv_total = 0;
    int run_len = 0;
    int idle_len = 0;
    bit gap_check = 1'b0;
    logic prev_rd = 1'b0, prev_ready = 1'b0, prev_core = 1'b0, prev_busy = 1'b0;
    logic [18:0] prev_addr = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A frame fetches every pixel once in raster order and scans MAX_ROW-2 windows.
    task automatic push_frame();
        for (int a = 0; a < NPIX; a++) exp_addr.push_back(a);
        for (int w = 0; w < NWIN; w++) begin
            exp_row.push_back(w);
            exp_top.push_back(w % 3);
        end
        exp_done++;
    endtask

    always @(negedge clk) begin
        logic rdy;
        if (!rst_n) begin
            exp_addr.delete();
            exp_row.delete();
            exp_top.delete();
            exp_done  = 0;
            run_len   = 0;
            gap_check = 1'b0;
        end else begin
            if (core_run_o && !prev_core) begin
                if (exp_row.size() == 0) check("win_expected", 0, 1);
                else begin
                    int r, t;
                    r = exp_row.pop_front();
                    t = exp_top.pop_front();
                    check("out_row", out_row_o, r);
                    check("top_sel", top_sel_o, t);
                    check("win_rows_ready", int'(rcv_total >= (r + 3) * MAX_COL), 1);
                end
            end
            if (core_run_o) run_len++;
            if (!core_run_o && prev_core) begin
                check("run_len", run_len, MAX_COL - 2);
                run_len = 0;
            end
            if (frame_done_o) begin
                check("done_expected", int'(exp_done > 0), 1);
                if (exp_done > 0) exp_done--;
                check("done_addr_left", exp_addr.size(), 0);
                check("done_win_left", exp_row.size(), 0);
            end
            if (prev_rd && !prev_ready && busy_o) begin
                check("stall_hold_addr", mem_addr_o, prev_addr);
                check("stall_hold_rd", mem_rd_o, 1);
            end
            if (busy_o && !prev_busy) begin
                if (gap_check) begin
                    check("idle_gap", idle_len, 1);
                    gap_check = 1'b0;
                end
                idle_len = 0;
            end else if (!busy_o) begin
                idle_len++;
            end
        end

        // Memory model: accepts per mode, returns beats in order at least a cycle later.
        case (mode)
            0:       rdy = 1'b1;
            1:       begin rdy = (ph % 3 == 0); ph++; end
            default: rdy = ($urandom_range(0, 3) != 0);
        endcase
        mem_ready_i  = rdy;
        mem_rvalid_i = (inflight > 0) && (mode != 2 || $urandom_range(0, 1) == 1);
        if (mem_rvalid_i) inflight--;
        if (mem_rd_o && rdy) begin
            inflight++;
            if (rst_n) begin
                if (exp_addr.size() == 0) check("addr_expected", 0, 1);
                else check("addr", mem_addr_o, exp_addr.pop_front());
            end
        end
        prev_rd    = mem_rd_o & rst_n;
        prev_ready = rdy;
        prev_addr  = mem_addr_o;
        prev_core  = core_run_o & rst_n;
        prev_busy  = busy_o;

        #1;
        check("data_en", data_en_o, int'(mem_rvalid_i && busy_o && !core_run_o && !frame_done_o));
        check("run_vs_en", int'(core_run_o && data_en_o), 0);
        check("addr_range", int'(mem_addr_o <= NPIX - 1), 1);
        if (!busy_o) rcv_total = 0;
        else if (mem_rvalid_i && !core_run_o && !frame_done_o) rcv_total++;
    end

    task automatic pulse_start(input bit push);
        @(posedge clk); #2;
        start_i = 1'b1;
        if (push) push_frame();
        @(posedge clk); #2;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!frame_done_o && n < 3000) begin @(negedge clk); n++; end
        check(name, frame_done_o, 1);
    endtask

    task automatic wait_run();
        int n = 0;
        while (!core_run_o && n < 3000) begin @(negedge clk); n++; end
        check("wait_run", core_run_o, 1);
    endtask

    task automatic wait_load2();
        int n = 0;
        while (!(mem_rd_o && mem_addr_o == 19'(4 * MAX_COL + 1)) && n < 3000) begin
            @(negedge clk); n++;
        end
        check("wait_load2", int'(mem_addr_o), 4 * MAX_COL + 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, frame_done_o, 0);
        check({tag, "_rd"}, mem_rd_o, 0);
        check({tag, "_addr"}, mem_addr_o, 0);
        check({tag, "_data_en"}, data_en_o, 0);
        check({tag, "_core_run"}, core_run_o, 0);
        check({tag, "_top_sel"}, top_sel_o, 0);
        check({tag, "_out_row"}, out_row_o, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        mode = 0;
        pulse_start(1);
        wait_done("frame_plain");
        repeat (3) @(posedge clk);

        mode = 1;
        pulse_start(1);
        wait_done("frame_backpressure");
        repeat (3) @(posedge clk);

        mode = 0;
        pulse_start(1);
        pulse_start(0);
        wait_run();
        pulse_start(0);
        wait_done("frame_start_ignored");
        repeat (3) @(posedge clk);

        mode = 2;
        for (int f = 0; f < 2; f++) begin
            pulse_start(1);
            wait_done("frame_random");
            repeat (3) @(posedge clk);
        end

        mode = 0;
        pulse_start(1);
        wait_load2();
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk); #2;
        check_all_zero("midreset");
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        pulse_start(1);
        check("restart_addr", mem_addr_o, 0);
        check("restart_rd", mem_rd_o, 1);
        check("restart_top_sel", top_sel_o, 0);
        check("restart_busy", busy_o, 1);
        wait_done("frame_after_reset");
        repeat (3) @(posedge clk);

        pulse_start(1);
        wait_done("frame_b2b_first");
        gap_check = 1'b1;
        pulse_start(1);
        wait_done("frame_b2b_second");
        repeat (5) @(posedge clk);
        check("gap_checked", int'(gap_check), 0);
        check("sb_empty", exp_addr.size() + exp_row.size() + exp_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
